// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse keyer: element encoding, unit multipliers
// for marks and gaps, the widest supported character and the keyer state enum.
// -----------------------------------------------------------------------------
package morse_pkg;

   // Element encoding inside a character code word.
   localparam logic DOT  = 1'b0;
   localparam logic DASH = 1'b1;

   // Durations expressed in Morse time units. Only 1 and 3 ever occur.
   typedef logic [1:0] units_t;
   localparam units_t DOT_UNITS      = 2'd1;
   localparam units_t DASH_UNITS     = 2'd3;
   localparam units_t ELEM_GAP_UNITS = 2'd1;
   localparam units_t CHAR_GAP_UNITS = 2'd3;

   // Longest character the encoder can present; wider widths are clamped.
   localparam int MAX_WIDTH = 5;

   typedef enum logic [2:0] {
      IDLE,
      MARK,
      GAP,
      CHAR_GAP,
      DONE
   } state_t;

endpackage

// File: rtl/morse_keyer_if.sv
// -----------------------------------------------------------------------------
// morse_keyer_if
// Character handshake and key outputs between the encoder (master) and the
// keyer (slave).
//   valid   : encoder presents code/width
//   code    : element bits, right-aligned, 0=dot 1=dash
//   width   : element count (0 = empty, 6..7 clamp to 5)
//   ready   : keyer can accept (transfer on valid && ready at a rising edge)
//   key_out : registered key, 1 = tone on
//   done    : one-cycle pulse at the end of each accepted character
//   busy    : inverse of ready
// -----------------------------------------------------------------------------
interface morse_keyer_if;

   logic       valid;
   logic [4:0] code;
   logic [2:0] width;
   logic       ready;
   logic       key_out;
   logic       done;
   logic       busy;

   modport master (
      output valid, code, width,
      input  ready, key_out, done, busy
   );

   modport slave (
      input  valid, code, width,
      output ready, key_out, done, busy
   );

endinterface

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
// Loadable down-counter that measures 1 or 3 Morse units. On load it takes
// units*UNIT_CYCLES-1, then counts down and holds at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : load the counter this cycle
//   units_i    : duration to load, in units (1 or 3)
//   zero_o     : counter currently equals zero
// -----------------------------------------------------------------------------
module morse_unit_timer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 5_000_000
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load_i,
   input  units_t units_i,
   output logic   zero_o
);

   localparam int CW = $clog2(3 * UNIT_CYCLES);
   localparam logic [CW-1:0] LOAD_1 = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] LOAD_3 = CW'(3 * UNIT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] load_val;

   // Only 1-unit and 3-unit durations exist, so a two-way select suffices.
   assign load_val = (units_i == DOT_UNITS) ? LOAD_1 : LOAD_3;

   always_comb begin
      // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for flops so all registers update from pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
// Serialises one Morse character (code/width from the encoder) into a timed
// key signal: dot = 1 unit, dash = 3 units, 1-unit gap between elements and a
// 3-unit gap after the last, then a one-cycle done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : morse_keyer_if.slave (valid/code/width in,
//                ready/key_out/done/busy out)
// All outputs are registered from the next state, so each appears in the
// cycle right after the edge that decided it.
// -----------------------------------------------------------------------------
module morse_keyer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 5_000_000
) (
   input  logic          clk,
   input  logic          rst_n,
   morse_keyer_if.slave  bus
);

   state_t     state_q, state_d;
   logic [4:0] code_q, code_d;
   logic [2:0] idx_q, idx_d;
   logic       key_q, key_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;

   logic       accept;
   logic [2:0] width_clamped;
   logic       timer_load;
   units_t     timer_units;
   logic       timer_zero;

   assign accept        = bus.valid && ready_q;
   assign width_clamped = (bus.width > 3'(MAX_WIDTH)) ? 3'(MAX_WIDTH) : bus.width;

   morse_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (timer_load),
      .units_i (timer_units),
      .zero_o  (timer_zero)
   );

   // State and registered outputs. key_out clears asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         code_q  <= '0;
         idx_q   <= '0;
         key_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         key_q   <= key_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   // Next state. IDLE and DONE both accept; a width-0 character goes straight
   // to DONE. The element index walks from width-1 down to 0.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               code_d  = bus.code;
               idx_d   = width_clamped - 3'd1;
               state_d = (width_clamped == 3'd0) ? DONE : MARK;
            end
         end
         MARK: begin
            if (timer_zero) begin
               state_d = (idx_q != 3'd0) ? GAP : CHAR_GAP;
            end
         end
         GAP: begin
            if (timer_zero) begin
               idx_d   = idx_q - 3'd1;
               state_d = MARK;
            end
         end
         CHAR_GAP: begin
            if (timer_zero) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs and timer control, all derived from the state being entered.
   // Every timed state differs from its predecessor, so a state change is
   // exactly a timer load.
   always_comb begin
      key_d       = (state_d == MARK);
      done_d      = (state_d == DONE);
      ready_d     = (state_d == IDLE) || (state_d == DONE);
      timer_load  = (state_d != state_q);
      timer_units = DOT_UNITS;
      case (state_d)
         MARK:     timer_units = (code_d[idx_d] == DASH) ? DASH_UNITS : DOT_UNITS;
         GAP:      timer_units = ELEM_GAP_UNITS;
         CHAR_GAP: timer_units = CHAR_GAP_UNITS;
         default:  timer_units = DOT_UNITS;
      endcase
   end

   assign bus.ready   = ready_q;
   assign bus.busy    = !ready_q;
   assign bus.key_out = key_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
// Self-checking bench for morse_keyer with UNIT_CYCLES=4. The expected key
// waveform of each character is built from the Morse timing rules (marks,
// element gaps, character gap) as a queue of bits, one per cycle after accept.
// Outputs are sampled 1 time step after each rising edge, so the sample taken
// after edge k-1 is the value "in cycle k" (accept edge = cycle 0).
// -----------------------------------------------------------------------------
module tb_morse_keyer;

   localparam int U = 4;

   logic clk = 1'b0;
   logic rst_n;

   morse_keyer_if bus ();

   morse_keyer #(
      .UNIT_CYCLES (U)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   bit exp_key[$];

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected key level for cycles 1..N after accept.
   task automatic build_expected(input logic [4:0] c, input logic [2:0] w);
      int n;
      int len;
      n = (w > 3'd5) ? 5 : int'(w);
      exp_key.delete();
      for (int e = n - 1; e >= 0; e--) begin
         len = c[e] ? 3 * U : U;
         repeat (len) exp_key.push_back(1'b1);
         if (e > 0) repeat (U) exp_key.push_back(1'b0);
      end
      if (n > 0) repeat (3 * U) exp_key.push_back(1'b0);
   endtask

   // Present a character, follow it through to done while scrambling the
   // inputs. With chain set, valid stays high and the next character is
   // presented in the done cycle.
   task automatic run_char(input logic [4:0] c, input logic [2:0] w, input bit chain,
                           input logic [4:0] nc, input logic [2:0] nw, input string tag);
      build_expected(c, w);
      bus.valid = 1'b1;
      bus.code  = c;
      bus.width = w;
      check({tag, " ready before accept"}, bus.ready, 1'b1);
      step();
      for (int i = 0; i < exp_key.size(); i++) begin
         check($sformatf("%s key cycle %0d", tag, i + 1), bus.key_out, exp_key[i]);
         check($sformatf("%s done cycle %0d", tag, i + 1), bus.done, 1'b0);
         check($sformatf("%s ready cycle %0d", tag, i + 1), bus.ready, 1'b0);
         check($sformatf("%s busy cycle %0d", tag, i + 1), bus.busy, 1'b1);
         bus.valid = chain ? 1'b1 : 1'($urandom_range(0, 1));
         bus.code  = 5'($urandom);
         bus.width = 3'($urandom);
         step();
      end
      check({tag, " done pulse"}, bus.done, 1'b1);
      check({tag, " ready at done"}, bus.ready, 1'b1);
      check({tag, " busy at done"}, bus.busy, 1'b0);
      check({tag, " key at done"}, bus.key_out, 1'b0);
      if (chain) begin
         bus.valid = 1'b1;
         bus.code  = nc;
         bus.width = nw;
      end else begin
         bus.valid = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] rc[13];
      logic [2:0] rw[13];

      // Reset with valid asserted: nothing may be accepted.
      rst_n     = 1'b0;
      bus.valid = 1'b1;
      bus.code  = 5'h1f;
      bus.width = 3'd5;
      repeat (3) begin
         step();
         check("reset key", bus.key_out, 1'b0);
         check("reset done", bus.done, 1'b0);
         check("reset ready", bus.ready, 1'b1);
         check("reset busy", bus.busy, 1'b0);
      end
      bus.valid = 1'b0;
      rst_n     = 1'b1;
      step();
      check("post-reset key", bus.key_out, 1'b0);
      check("post-reset ready", bus.ready, 1'b1);
      check("post-reset done", bus.done, 1'b0);

      // Directed characters.
      run_char(5'b00000, 3'd1, 1'b0, 5'd0, 3'd0, "E");
      run_char(5'b00001, 3'd2, 1'b0, 5'd0, 3'd0, "A");
      run_char(5'b10101, 3'd0, 1'b0, 5'd0, 3'd0, "empty");
      run_char(5'b11111, 3'd7, 1'b0, 5'd0, 3'd0, "clamp");

      // Back-to-back T then E with valid held and code mutating while busy.
      run_char(5'b00001, 3'd1, 1'b1, 5'b00000, 3'd1, "T chained");
      run_char(5'b00000, 3'd1, 1'b0, 5'd0, 3'd0, "E after T");
      step();
      check("idle after chain ready", bus.ready, 1'b1);
      check("idle after chain done", bus.done, 1'b0);

      // Reset in the middle of a dash (cycle 6 of T).
      bus.valid = 1'b1;
      bus.code  = 5'b00001;
      bus.width = 3'd1;
      step();
      bus.valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("T pre-reset key cycle %0d", i), bus.key_out, 1'b1);
         step();
      end
      check("T key cycle 6", bus.key_out, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async key drop", bus.key_out, 1'b0);
      check("no done at reset", bus.done, 1'b0);
      repeat (3) begin
         step();
         check("held reset key", bus.key_out, 1'b0);
         check("held reset done", bus.done, 1'b0);
         check("held reset ready", bus.ready, 1'b1);
      end
      rst_n = 1'b1;
      step();
      check("after mid reset ready", bus.ready, 1'b1);
      check("after mid reset done", bus.done, 1'b0);
      run_char(5'b00001, 3'd2, 1'b0, 5'd0, 3'd0, "A after reset");

      // Randomized characters, randomly chained.
      for (int i = 0; i < 13; i++) begin
         rc[i] = 5'($urandom);
         rw[i] = 3'($urandom_range(0, 7));
      end
      for (int i = 0; i < 12; i++) begin
         run_char(rc[i], rw[i], 1'($urandom_range(0, 1)), rc[i + 1], rw[i + 1],
                  $sformatf("rand%0d", i));
      end
      bus.valid = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
